mist1032isa_uart_rx_fifo: RTL

MIST1032ISA_UART_RX_FIFO -- requirements
Module: mist1032isa_uart_rx_fifo

---
 rtl/mist1032isa_uart_rx_fifo_pkg.sv | 11 +
 rtl/mist1032isa_uart_rx_fifo_if.sv | 39 +++
 rtl/mist1032isa_uart_rx_fifo_ram.sv | 31 +++
 rtl/mist1032isa_uart_rx_fifo.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mist1032isa_uart_rx_fifo_pkg.sv
// Shared UART definitions (the mist1032isa_uart_defines set): default receive
// FIFO depth and the byte width. The receiver and transmitter use the same
// constants.
package mist1032isa_uart_rx_fifo_pkg;

    localparam int UART_BYTE_W         = 8;
    localparam int UART_RXFIFO_DEPTH_N = 4;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/mist1032isa_uart_rx_fifo_if.sv
// Bus between the UART receive FIFO and its producer/consumer.
// The master side drives the strobes. The slave side is the FIFO.
// MIST1032ISA_UART_RXFIFO_OVFCNT_EN adds the dropped-byte counter output.
interface mist1032isa_uart_rx_fifo_if
    import mist1032isa_uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_N = UART_RXFIFO_DEPTH_N
);
    logic               iRX_VALID;
    uart_byte_t         iRX_DATA;
    logic               iRD_REQ;
    logic               iFLUSH;
    logic               iOVF_CLEAR;
    logic               oRD_EMPTY;
    uart_byte_t         oRD_DATA;
    logic               oFULL;
    logic [DEPTH_N:0]   oCOUNT;
    logic               oOVERFLOW;
`ifdef MIST1032ISA_UART_RXFIFO_OVFCNT_EN
    logic [7:0]         oOVF_COUNT;
`endif

    modport master (
        output iRX_VALID, iRX_DATA, iRD_REQ, iFLUSH, iOVF_CLEAR,
        input  oRD_EMPTY, oRD_DATA, oFULL, oCOUNT, oOVERFLOW
`ifdef MIST1032ISA_UART_RXFIFO_OVFCNT_EN
        , input oOVF_COUNT
`endif
    );

    modport slave (
        input  iRX_VALID, iRX_DATA, iRD_REQ, iFLUSH, iOVF_CLEAR,
        output oRD_EMPTY, oRD_DATA, oFULL, oCOUNT, oOVERFLOW
`ifdef MIST1032ISA_UART_RXFIFO_OVFCNT_EN
        , output oOVF_COUNT
`endif
    );

endinterface

// File: rtl/mist1032isa_uart_rx_fifo_ram.sv
// Byte storage for the receive FIFO. It has one synchronous write port and one
// asynchronous read port. It has no reset.
module mist1032isa_uart_rx_fifo_ram
    import mist1032isa_uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = UART_RXFIFO_DEPTH_N
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  uart_byte_t        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output uart_byte_t        rd_data_o
);

    uart_byte_t mem_q [1 << ADDR_W];

    // Store the byte at the write pointer.
    // NOTE: the array is deliberately not reset. The occupancy counter in the
    // parent decides what is valid, so a reset port here would only cost
    // flops and block RAM inference.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read is combinational so that the oldest byte falls through.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mist1032isa_uart_rx_fifo.sv
// UART receive FIFO. It is a circular buffer of 2^DEPTH_N bytes with
// first-word fall-through reads, a sticky overflow flag and a flush input.
// Optional feature: MIST1032ISA_UART_RXFIFO_OVFCNT_EN adds a saturating
// counter of dropped bytes on oOVF_COUNT.
module mist1032isa_uart_rx_fifo
    import mist1032isa_uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_N = UART_RXFIFO_DEPTH_N
) (
    input  logic                       iCLOCK,
    input  logic                       inRESET,
    mist1032isa_uart_rx_fifo_if.slave  rx_fifo_if
);

    localparam logic [DEPTH_N:0] FULL_CNT = {1'b1, {DEPTH_N{1'b0}}};

    logic [DEPTH_N-1:0] wptr_q, wptr_d;
    logic [DEPTH_N-1:0] rptr_q, rptr_d;
    logic [DEPTH_N:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               empty, full, pop, push, drop;
    uart_byte_t         ram_rd;
`ifdef MIST1032ISA_UART_RXFIFO_OVFCNT_EN
    logic [7:0]         ovf_cnt_q, ovf_cnt_d;
`endif

    // Decode push, pop and drop, then form the next pointer, count and flag state.
    // A flush overrides both a push and a pop.
    // NOTE: every signal gets a default at the top of this block. A path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        pop     = rx_fifo_if.iRD_REQ && !empty && !rx_fifo_if.iFLUSH;
        push    = rx_fifo_if.iRX_VALID && (!full || pop) && !rx_fifo_if.iFLUSH;
        drop    = rx_fifo_if.iRX_VALID && full && !rx_fifo_if.iRD_REQ && !rx_fifo_if.iFLUSH;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (rx_fifo_if.iFLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + DEPTH_N'(1);
            if (pop)  rptr_d = rptr_q + DEPTH_N'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (DEPTH_N+1)'(1);
                2'b01:   count_d = count_q - (DEPTH_N+1)'(1);
                default: count_d = count_q;
            endcase
        end

        // A new overflow in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (rx_fifo_if.iOVF_CLEAR) begin
            ovf_d = 1'b0;
        end
    end

    // Register pointers, occupancy and the overflow flag.
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples the values from before the edge, whatever the block order.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MIST1032ISA_UART_RXFIFO_OVFCNT_EN
    // Next value of the dropped-byte counter. It saturates at 8'hFF. A drop
    // in the same cycle as a clear takes priority over the clear.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
        end else if (rx_fifo_if.iOVF_CLEAR) begin
            ovf_cnt_d = 8'h00;
        end
    end

    // Register the dropped-byte counter.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) ovf_cnt_q <= 8'h00;
        else          ovf_cnt_q <= ovf_cnt_d;
    end

    assign rx_fifo_if.oOVF_COUNT = ovf_cnt_q;
`endif

    mist1032isa_uart_rx_fifo_ram #(
        .ADDR_W (DEPTH_N)
    ) u_ram (
        .clk_i     (iCLOCK),
        .wr_en_i   (push),
        .wr_addr_i (wptr_q),
        .wr_data_i (rx_fifo_if.iRX_DATA),
        .rd_addr_i (rptr_q),
        .rd_data_o (ram_rd)
    );

    // Status comes from registered state only. Stale RAM contents are masked
    // while the FIFO is empty.
    assign rx_fifo_if.oRD_EMPTY = empty;
    assign rx_fifo_if.oFULL     = full;
    assign rx_fifo_if.oCOUNT    = count_q;
    assign rx_fifo_if.oOVERFLOW = ovf_q;
    assign rx_fifo_if.oRD_DATA  = empty ? 8'h00 : ram_rd;

endmodule
